// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcodes, enums and decoded-lane struct for the decode stage
package decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INSTR_WFI = 32'h10500073;

  // Low three bits follow funct3; bit 3 marks the subtract / arithmetic-shift variants.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SLL  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_AND  = 4'd7,
    ALU_SUB  = 4'd8,
    ALU_SRA  = 4'd13
  } aluop_e;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

  typedef enum logic {ST_RUN, ST_WFI_WAIT} state_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rd_valid;
    logic        rs1_valid;
    logic        rs2_valid;
    logic [31:0] imm;
    aluop_e      aluop;
    logic        is_branch;
    logic        is_jal;
    logic        is_wfi;
    logic        illegal;
  } lane_dec_t;

  function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_type_e t);
    logic [31:0] r;
    r = '0;
    case (t)
      IMM_I:   r = {{20{i[31]}}, i[31:20]};
      IMM_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   r = {i[31:12], 12'b0};
      IMM_J:   r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - group-in / decoded-group-out bundle for decode_stage
interface decode_stage_if #(
  parameter int LANES = 2,
  parameter int XLEN  = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*XLEN-1:0] in_instr;
  logic [XLEN-1:0]       in_pc;
  logic                  flush;
  logic                  wake;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       out_pc;
  logic [LANES-1:0]      out_lane_valid;
  logic [LANES*5-1:0]    out_rd;
  logic [LANES*5-1:0]    out_rs1;
  logic [LANES*5-1:0]    out_rs2;
  logic [LANES-1:0]      out_rd_valid;
  logic [LANES-1:0]      out_rs1_valid;
  logic [LANES-1:0]      out_rs2_valid;
  logic [LANES*XLEN-1:0] out_imm;
  logic [LANES*4-1:0]    out_aluop;
  logic [LANES-1:0]      out_is_branch;
  logic [LANES-1:0]      out_is_jal;
  logic [LANES-1:0]      out_is_wfi;
  logic [LANES-1:0]      out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, flush, wake, out_ready,
    input  in_ready, out_valid, out_pc, out_lane_valid, out_rd, out_rs1, out_rs2,
    input  out_rd_valid, out_rs1_valid, out_rs2_valid, out_imm, out_aluop,
    input  out_is_branch, out_is_jal, out_is_wfi, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, wake, out_ready,
    output in_ready, out_valid, out_pc, out_lane_valid, out_rd, out_rs1, out_rs2,
    output out_rd_valid, out_rs1_valid, out_rs2_valid, out_imm, out_aluop,
    output out_is_branch, out_is_jal, out_is_wfi, out_illegal
  );
endinterface

// File: rtl/decode_lane.sv
// rtl/decode_lane.sv - combinational RV32I + WFI decoder for one instruction
module decode_lane
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output lane_dec_t   dec
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  // Classify the opcode and select operand usage, immediate format and ALU op.
  always_comb begin
    imm_type_e it;
    it            = IMM_NONE;
    dec           = '0;
    dec.rd        = instr[11:7];
    dec.rs1       = instr[19:15];
    dec.rs2       = instr[24:20];
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        dec.rd_valid = 1'b1;
        it           = IMM_U;
      end
      OPC_JAL: begin
        dec.rd_valid = 1'b1;
        dec.is_jal   = 1'b1;
        it           = IMM_J;
      end
      // JALR is an unconditional jump too, so it shares the jump flag and ends the group.
      OPC_JALR: begin
        if (f3 == 3'b000) begin
          dec.rd_valid  = 1'b1;
          dec.rs1_valid = 1'b1;
          dec.is_jal    = 1'b1;
          it            = IMM_I;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_BRANCH: begin
        if (f3 == 3'b010 || f3 == 3'b011) begin
          dec.illegal = 1'b1;
        end else begin
          dec.rs1_valid = 1'b1;
          dec.rs2_valid = 1'b1;
          dec.is_branch = 1'b1;
          it            = IMM_B;
          dec.aluop     = (f3[2:1] == 2'b00) ? ALU_SUB :
                          (f3[2:1] == 2'b10) ? ALU_SLT : ALU_SLTU;
        end
      end
      OPC_LOAD: begin
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) begin
          dec.illegal = 1'b1;
        end else begin
          dec.rd_valid  = 1'b1;
          dec.rs1_valid = 1'b1;
          it            = IMM_I;
        end
      end
      OPC_STORE: begin
        if (f3 > 3'b010) begin
          dec.illegal = 1'b1;
        end else begin
          dec.rs1_valid = 1'b1;
          dec.rs2_valid = 1'b1;
          it            = IMM_S;
        end
      end
      OPC_OP_IMM: begin
        if ((f3 == 3'b001 && f7 != 7'b0000000) ||
            (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000)) begin
          dec.illegal = 1'b1;
        end else begin
          dec.rd_valid  = 1'b1;
          dec.rs1_valid = 1'b1;
          it            = IMM_I;
          // Only SRAI uses the alternate bit; ADDI with imm[10] set stays ADD.
          dec.aluop     = aluop_e'({(f3 == 3'b101) && f7[5], f3});
        end
      end
      OPC_OP: begin
        if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
          dec.rd_valid  = 1'b1;
          dec.rs1_valid = 1'b1;
          dec.rs2_valid = 1'b1;
          dec.aluop     = aluop_e'({f7[5], f3});
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_SYSTEM: begin
        if (instr == INSTR_WFI) dec.is_wfi = 1'b1;
        else                    dec.illegal = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.imm = imm_gen(instr, it);
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - multi-lane decode with 2-entry skid buffer and WFI wait
module decode_stage
  import decode_pkg::*;
#(
  parameter int LANES = 2,
  parameter int XLEN  = 32
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);

  lane_dec_t        in_dec [LANES];
  logic [LANES-1:0] in_stop;
  logic [LANES-1:0] in_wfi;
  logic [LANES-1:0] in_mask;

  lane_dec_t        buf_dec  [2][LANES];
  logic [XLEN-1:0]  buf_pc   [2];
  logic [LANES-1:0] buf_mask [2];

  logic       rd_ptr, rd_ptr_n;
  logic       wr_ptr, wr_ptr_n;
  logic [1:0] count, count_n;
  logic       ready_q, ready_n;
  state_e     state, state_n;

  logic in_ready_int;
  logic out_valid_int;
  logic push, pop, wfi_hit;

  for (genvar g = 0; g < LANES; g++) begin : g_in
    decode_lane u_dec (
      .instr (32'(bus.in_instr[g*XLEN +: XLEN])),
      .dec   (in_dec[g])
    );
    assign in_stop[g] = in_dec[g].is_branch | in_dec[g].is_jal | in_dec[g].is_wfi | in_dec[g].illegal;
    assign in_wfi[g]  = in_dec[g].is_wfi;
  end

  // Lanes after the first control-flow, WFI or illegal lane are not issued.
  always_comb begin
    in_mask    = '0;
    in_mask[0] = 1'b1;
    for (int i = 1; i < LANES; i++) begin
      in_mask[i] = in_mask[i-1] & ~in_stop[i-1];
    end
  end

  // Flush is a hard kill: no handshake may complete in the cycle it is asserted.
  assign in_ready_int  = ready_q & ~bus.flush;
  assign out_valid_int = (count != 2'd0);
  assign push          = bus.in_valid & in_ready_int;
  assign pop           = out_valid_int & bus.out_ready;
  assign wfi_hit       = |(in_wfi & in_mask);

  // Next buffer occupancy, pointers, FSM state and registered ready.
  always_comb begin
    rd_ptr_n = rd_ptr;
    wr_ptr_n = wr_ptr;
    state_n  = state;
    count_n  = count + {1'b0, push} - {1'b0, pop};
    if (push) wr_ptr_n = ~wr_ptr;
    if (pop)  rd_ptr_n = ~rd_ptr;
    case (state)
      ST_RUN:      if (push && wfi_hit) state_n = ST_WFI_WAIT;
      ST_WFI_WAIT: if (bus.wake || bus.flush) state_n = ST_RUN;
      default:     state_n = ST_RUN;
    endcase
    if (bus.flush) begin
      count_n  = 2'd0;
      rd_ptr_n = 1'b0;
      wr_ptr_n = 1'b0;
    end
    ready_n = (count_n != 2'd2) && (state_n == ST_RUN);
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_RUN;
      count   <= 2'd0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      rd_ptr  <= rd_ptr_n;
      wr_ptr  <= wr_ptr_n;
      ready_q <= ready_n;
    end
  end

  // Buffer payload; outputs are masked by out_valid so stale entries never leak.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]   <= bus.in_pc;
      buf_mask[wr_ptr] <= in_mask;
      for (int i = 0; i < LANES; i++) begin
        buf_dec[wr_ptr][i] <= in_dec[i];
      end
    end
  end

  assign bus.in_ready       = in_ready_int;
  assign bus.out_valid      = out_valid_int;
  assign bus.out_pc         = out_valid_int ? buf_pc[rd_ptr] : '0;
  assign bus.out_lane_valid = out_valid_int ? buf_mask[rd_ptr] : '0;

  for (genvar g = 0; g < LANES; g++) begin : g_out
    lane_dec_t       hd;
    logic [XLEN-1:0] imm_x;
    assign hd    = out_valid_int ? buf_dec[rd_ptr][g] : '0;
    assign imm_x = XLEN'(signed'(hd.imm));
    assign bus.out_rd[g*5 +: 5]       = hd.rd;
    assign bus.out_rs1[g*5 +: 5]      = hd.rs1;
    assign bus.out_rs2[g*5 +: 5]      = hd.rs2;
    assign bus.out_rd_valid[g]        = hd.rd_valid;
    assign bus.out_rs1_valid[g]       = hd.rs1_valid;
    assign bus.out_rs2_valid[g]       = hd.rs2_valid;
    assign bus.out_imm[g*XLEN +: XLEN] = imm_x;
    assign bus.out_aluop[g*4 +: 4]    = hd.aluop;
    assign bus.out_is_branch[g]       = hd.is_branch;
    assign bus.out_is_jal[g]          = hd.is_jal;
    assign bus.out_is_wfi[g]          = hd.is_wfi;
    assign bus.out_illegal[g]         = hd.illegal;
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed vector and sequence bench for decode_stage
module tb_decode_stage;

  localparam int LANES = 2;
  localparam int XLEN  = 32;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_if #(.LANES(LANES), .XLEN(XLEN)) bus ();

  decode_stage #(.LANES(LANES), .XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] i0, i1;
    logic [1:0]  mask;
    logic [4:0]  rd, rs1, rs2;
    logic        rdv, rs1v, rs2v;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        br, jal, ill0, ill1;
  } vec_t;

  vec_t vt [10];

  int sent, recvd, occ;
  logic [1:0] pat [4];

  initial begin
    vt[0] = '{32'hFFF10093, NOP, 2'b11, 5'd1, 5'd2, 5'd31, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{32'h0000006F, NOP, 2'b01, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h00000000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[2] = '{32'h00000000, NOP, 2'b01, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h00000000, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[3] = '{32'h405201B3, NOP, 2'b11, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1, 32'h00000000, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4] = '{32'hFE209CE3, NOP, 2'b01, 5'd25, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1, 32'hFFFFFFF8, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[5] = '{32'h123452B7, NOP, 2'b11, 5'd5, 5'd8, 5'd3, 1'b1, 1'b0, 1'b0, 32'h12345000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[6] = '{32'hFE63AE23, NOP, 2'b11, 5'd28, 5'd7, 5'd6, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFC, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7] = '{32'h4030D093, NOP, 2'b11, 5'd1, 5'd1, 5'd3, 1'b1, 1'b1, 1'b0, 32'h00000403, 4'd13, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[8] = '{NOP, 32'hFFFFFFFF, 2'b11, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[9] = '{32'hFFFFF117, NOP, 2'b11, 5'd2, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0, 32'hFFFFF000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    pat[0] = 2'd1; pat[1] = 2'd0; pat[2] = 2'd0; pat[3] = 2'd1;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.in_pc    = '0;
    bus.flush    = 1'b0;
    bus.wake     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst.in_ready", bus.in_ready, 0);
    chk("rst.out_valid", bus.out_valid, 0);
    chk("rst.lane_valid", bus.out_lane_valid, 0);
    chk("rst.imm0", bus.out_imm[31:0], 0);
    chk("rst.illegal", bus.out_illegal, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst.in_ready", bus.in_ready, 1);

    // Table of single-group decodes.
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_instr = {vt[k].i1, vt[k].i0};
      bus.in_pc    = 32'h1000 + 32'(k * 8);
      @(negedge clk);
      chk($sformatf("v%0d.ready", k), bus.in_ready, 1);
      chk($sformatf("v%0d.pre_valid", k), bus.out_valid, 0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d.out_valid", k), bus.out_valid, 1);
      chk($sformatf("v%0d.pc", k), bus.out_pc, 32'h1000 + 32'(k * 8));
      chk($sformatf("v%0d.mask", k), bus.out_lane_valid, vt[k].mask);
      chk($sformatf("v%0d.rd", k), bus.out_rd[4:0], vt[k].rd);
      chk($sformatf("v%0d.rs1", k), bus.out_rs1[4:0], vt[k].rs1);
      chk($sformatf("v%0d.rs2", k), bus.out_rs2[4:0], vt[k].rs2);
      chk($sformatf("v%0d.rdv", k), bus.out_rd_valid[0], vt[k].rdv);
      chk($sformatf("v%0d.rs1v", k), bus.out_rs1_valid[0], vt[k].rs1v);
      chk($sformatf("v%0d.rs2v", k), bus.out_rs2_valid[0], vt[k].rs2v);
      chk($sformatf("v%0d.imm", k), bus.out_imm[31:0], vt[k].imm);
      chk($sformatf("v%0d.aluop", k), bus.out_aluop[3:0], vt[k].alu);
      chk($sformatf("v%0d.branch", k), bus.out_is_branch[0], vt[k].br);
      chk($sformatf("v%0d.jal", k), bus.out_is_jal[0], vt[k].jal);
      chk($sformatf("v%0d.ill0", k), bus.out_illegal[0], vt[k].ill0);
      chk($sformatf("v%0d.ill1", k), bus.out_illegal[1], vt[k].ill1);
    end

    // WFI: in_ready held low until wake, presented group held stable.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = {NOP, 32'h10500073};
    bus.in_pc     = 32'h3000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("wfi.out_valid", bus.out_valid, 1);
    chk("wfi.is_wfi0", bus.out_is_wfi[0], 1);
    chk("wfi.mask", bus.out_lane_valid, 2'b01);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("wfi.hold_ready%0d", c), bus.in_ready, 0);
      chk($sformatf("wfi.hold_pc%0d", c), bus.out_pc, 32'h3000);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.wake      = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("wfi.wake_same_cycle", bus.in_ready, 0);
    @(posedge clk); #1;
    bus.wake = 1'b0;
    @(negedge clk);
    chk("wfi.ready_after_wake", bus.in_ready, 1);
    chk("wfi.drained", bus.out_valid, 0);

    // Continuous input against out_ready pattern 1,0,0,1.
    sent = 0; recvd = 0;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1;
      bus.out_ready = pat[c % 4][0];
      bus.in_valid  = 1'b1;
      bus.in_instr  = {NOP, NOP};
      bus.in_pc     = 32'h2000 + 32'(sent * 8);
      @(negedge clk);
      occ = sent - recvd;
      chk($sformatf("tp%0d.ready", c), bus.in_ready, (occ != 2));
      chk($sformatf("tp%0d.valid", c), bus.out_valid, (occ != 0));
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("tp%0d.pc", c), bus.out_pc, 32'h2000 + 32'(recvd * 8));
        recvd++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6 && recvd < sent; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        chk("tp.drain_pc", bus.out_pc, 32'h2000 + 32'(recvd * 8));
        recvd++;
      end
      @(posedge clk); #1;
    end
    chk("tp.all_delivered", 32'(recvd), 32'(sent));
    chk("tp.sent_enough", 32'(sent >= 12), 1);

    // Two buffered groups, then flush.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = {NOP, NOP};
    bus.in_pc     = 32'h4000;
    @(posedge clk); #1;
    bus.in_pc = 32'h4008;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("fl.full_ready", bus.in_ready, 0);
    chk("fl.head_pc", bus.out_pc, 32'h4000);
    @(posedge clk); #1;
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h4010;
    @(negedge clk);
    chk("fl.ready_during", bus.in_ready, 0);
    @(posedge clk); #1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("fl.empty%0d", c), bus.out_valid, 0);
      chk($sformatf("fl.ready%0d", c), bus.in_ready, 1);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h5000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("fl.new_valid", bus.out_valid, 1);
    chk("fl.new_pc", bus.out_pc, 32'h5000);

    // Reset in mid-operation discards the held group.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h6000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mrst.out_valid", bus.out_valid, 0);
    chk("mrst.in_ready", bus.in_ready, 0);
    chk("mrst.pc", bus.out_pc, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst.ready_back", bus.in_ready, 1);
    chk("mrst.still_empty", bus.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 LANES, default 2, number of instructions decoded per group (1..4).
REQ-002 XLEN, default 32, instruction, PC and immediate width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid / in_ready  input / output  1 / 1  upstream group handshake.
REQ-006 in_instr  input  LANES*XLEN  lane i at bits [i*XLEN +: XLEN].
REQ-007 in_pc  input  XLEN  PC of lane 0; lane i PC = in_pc + 4*i.
REQ-008 flush  input  1  discard all buffered groups; leave WFI wait.
REQ-009 wake  input  1  level; releases WFI wait.
REQ-010 out_valid / out_ready  output / input  1 / 1  downstream handshake.
REQ-011 out_pc  output  XLEN  PC of lane 0 of the presented group.
REQ-012 out_lane_valid  output  LANES  per-lane issue-valid mask.
REQ-013 out_rd, out_rs1, out_rs2  output  LANES*5 each  register indices.
REQ-014 out_rd_valid, out_rs1_valid, out_rs2_valid  output  LANES each  operand-use flags.
REQ-015 out_imm  output  LANES*XLEN  sign-extended immediate (I/S/B/U/J by type).
REQ-016 out_aluop  output  LANES*4  ALU op (package encoding).
REQ-017 out_is_branch, out_is_jal, out_is_wfi, out_illegal  output  LANES each  class flags.

Function
REQ-018 Each lane SHALL decode RV32I base ops (LUI, AUIPC, JAL, JALR, branches, loads, stores, OP-IMM, OP) and WFI; any other encoding sets out_illegal for that lane.
REQ-019 Transfer occurs when valid and ready are both high on a rising edge; a group accepted at edge N SHALL be presented at out_valid from edge N onward (1-cycle latency).
REQ-020 A 2-entry skid buffer SHALL sustain one group per cycle; in_ready SHALL be registered and low only when both entries are occupied, in WFI_WAIT, or flush is high.
REQ-021 Outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 Lane truncation: lanes after the first lane with is_branch, is_jal, is_wfi or illegal SHALL have out_lane_valid=0; lane 0 is always 1 in a presented group.
REQ-023 Immediates SHALL be sign-extended from bit 31; B/J immediates have bit 0 = 0; U immediates have low 12 bits zero.
REQ-024 aluop encoding: ADD 0, SLL 1, SLT 2, SLTU 3, XOR 4, SRL 5, OR 6, AND 7, SUB 8, SRA 13; loads/stores/JAL/JALR/AUIPC use ADD; BEQ/BNE use SUB; BLT/BGE use SLT; BLTU/BGEU use SLTU.
REQ-025 FSM states RUN, WFI_WAIT; RUN->WFI_WAIT on acceptance of a group with any valid WFI lane; WFI_WAIT->RUN when wake=1 or flush=1 (next edge).
REQ-026 flush SHALL empty both buffer entries at the next edge, force out_valid=0 the following cycle, and block acceptance that cycle even if in_valid=1.
REQ-027 Simultaneous out transfer and in transfer with one entry occupied SHALL keep occupancy at one.
REQ-028 Simultaneous flush and out_ready=1 with out_valid=1: the presented group counts as transferred; buffer still empties.

Reset
REQ-029 While rst=1: buffer empty, FSM=RUN, out_valid=0, in_ready=0; all data outputs 0.
REQ-030 in_ready SHALL rise on the first edge after rst deasserts; rst mid-operation discards all groups.

Structure
REQ-031 Package decode_pkg SHALL hold opcode constants, aluop enum, imm-type enum, and the per-lane decoded struct.
REQ-032 A combinational sub-module decode_lane SHALL decode one instruction and be instantiated LANES times.

Verification
REQ-033 LANES=2, lane0 0xFFF10093 (ADDI x1,x2,-1), lane1 0x00000013 -> rd=1, rs1=2, imm=0xFFFFFFFF, aluop=0, lane mask 2'b11, 1-cycle latency.
REQ-034 lane0 0x0000006F (JAL x0,0), lane1 NOP -> is_jal[0]=1, out_lane_valid=2'b01.
REQ-035 lane0 0x10500073 (WFI) -> is_wfi[0]=1, in_ready=0 until wake=1, then 1 one cycle later.
REQ-036 lane0 0x00000000 -> out_illegal[0]=1, out_lane_valid=2'b01.
REQ-037 Continuous in_valid, out_ready toggling 1,0,0,1 -> no group lost or duplicated, in_ready drops only with two entries held.
REQ-038 Two groups buffered, flush=1 -> out_valid=0 for one cycle, neither group presented afterwards.
